// File: rtl/freq_report_uart.sv
// Formats each frequency-counter result as "AA:VVVVVVVV\r\n" and transmits it as 8N1 UART.
// A single pending slot holds the next result while the current line is on the wire.
module freq_report_uart #(
  parameter int unsigned CLK_DIV = 347
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        strobe,
  input  logic [7:0]  addr,
  input  logic [31:0] value,
  input  logic        clear_ovr,
  output logic        ser_tx,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] lines_sent
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [3:0]  char_q;
  logic        ser_q;
  logic [7:0]  line_addr_q;
  logic [31:0] line_value_q;

  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  pend_addr_q, pend_addr_d;
  logic [31:0] pend_value_q, pend_value_d;
  logic        ovr_q, ovr_d;
  logic [15:0] lines_sent_q, lines_sent_d;

  logic        bit_done;
  logic        consume;
  logic        line_done;
  logic [31:0] val_shift;
  logic [7:0]  cur_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign bit_done  = (cnt_q == DIV_LAST);
  assign consume   = (state_q == IDLE) && pend_valid_q;
  assign line_done = (state_q == STOP) && bit_done && (char_q == 4'd12);

  // Character currently on the wire, selected from the captured line buffer.
  always_comb begin
    val_shift = line_value_q << {char_q - 4'd3, 2'b00};
    case (char_q)
      4'd0:    cur_char = hex_ascii(line_addr_q[7:4]);
      4'd1:    cur_char = hex_ascii(line_addr_q[3:0]);
      4'd2:    cur_char = 8'h3A;
      4'd11:   cur_char = 8'h0D;
      4'd12:   cur_char = 8'h0A;
      default: cur_char = hex_ascii(val_shift[31:28]);
    endcase
  end

  // Overwriting an unconsumed entry raises overrun; a consume in the same cycle hands the old entry to TX.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_value_d = pend_value_q;
    ovr_d        = ovr_q;
    if (clear_ovr) ovr_d = 1'b0;
    if (strobe) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = addr;
      pend_value_d = value;
      if (pend_valid_q && !consume) ovr_d = 1'b1;
    end else if (consume) begin
      pend_valid_d = 1'b0;
    end
    lines_sent_d = line_done ? lines_sent_q + 16'd1 : lines_sent_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      char_q       <= '0;
      ser_q        <= 1'b1;
      line_addr_q  <= '0;
      line_value_q <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_value_q <= '0;
      ovr_q        <= 1'b0;
      lines_sent_q <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_value_q <= pend_value_d;
      ovr_q        <= ovr_d;
      lines_sent_q <= lines_sent_d;
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          bit_q  <= '0;
          char_q <= '0;
          ser_q  <= 1'b1;
          if (pend_valid_q) begin
            line_addr_q  <= pend_addr_q;
            line_value_q <= pend_value_q;
            ser_q        <= 1'b0;
            state_q      <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            ser_q   <= cur_char[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              ser_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              ser_q <= cur_char[bit_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (char_q == 4'd12) begin
              state_q <= IDLE;
            end else begin
              char_q  <= char_q + 4'd1;
              ser_q   <= 1'b0;
              state_q <= START;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ser_tx     = ser_q;
  assign busy       = pend_valid_q || (state_q != IDLE);
  assign overrun    = ovr_q;
  assign lines_sent = lines_sent_q;

endmodule

// File: tb/tb_freq_report_uart.sv
// Scoreboard bench for freq_report_uart: instance A (divider 4) takes the directed and random
// traffic, instance B (divider 2) covers the minimum divider and the lines_sent wrap.
module tb_freq_report_uart;

  localparam int DIV_A = 4;
  localparam int DIV_B = 2;

  typedef struct {
    int          dut;
    int          startCyc;
    logic [7:0]  addr;
    logic [31:0] value;
  } lineT;

  logic clk = 1'b0;
  logic [1:0]       resetnS;
  logic [1:0]       strobeS;
  logic [1:0]       clrS;
  logic [1:0][7:0]  addrS;
  logic [1:0][31:0] valueS;
  logic             presetLinesB;
  wire  [1:0]       serTx;
  wire  [1:0]       busyO;
  wire  [1:0]       overrunO;
  wire  [1:0][15:0] linesO;

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  bit          mPendValid [2];
  logic [7:0]  mPendAddr  [2];
  logic [31:0] mPendValue [2];
  int          mLineEnd   [2];
  bit          mLineLive  [2];
  bit          mOverrun   [2];
  logic [15:0] mLines     [2];
  bit          abortLine  [2];
  lineT        expQ [$];

  bit          monActive [2];
  int          monStart  [2];
  lineT        monLine   [2];
  int          badCycles [2];
  logic [7:0]  gotChar   [2];

  freq_report_uart #(.CLK_DIV(DIV_A)) dutA (
    .clk(clk), .resetn(resetnS[0]), .strobe(strobeS[0]), .addr(addrS[0]), .value(valueS[0]),
    .clear_ovr(clrS[0]), .ser_tx(serTx[0]), .busy(busyO[0]), .overrun(overrunO[0]),
    .lines_sent(linesO[0])
  );

  freq_report_uart #(.CLK_DIV(DIV_B)) dutB (
    .clk(clk), .resetn(resetnS[1]), .strobe(strobeS[1]), .addr(addrS[1]), .value(valueS[1]),
    .clear_ovr(clrS[1]), .ser_tx(serTx[1]), .busy(busyO[1]), .overrun(overrunO[1]),
    .lines_sent(linesO[1])
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expected text of a line, built as a formatted string rather than digit by digit.
  function automatic logic [7:0] lineChar(input lineT l, input int idx);
    string s;
    s = $sformatf("%02h:%08h", l.addr, l.value);
    s = s.toupper();
    if (idx == 11) return 8'h0D;
    if (idx == 12) return 8'h0A;
    return s[idx];
  endfunction

  // Reference model: one pending slot, a line occupies the transmitter for 130 bit times,
  // and the transmitter can pick up new work one cycle after a line completes.
  task automatic modelStep();
    int div;
    bit consume;
    bit ovrEvent;
    cyc++;
    if (presetLinesB) mLines[1] = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      div = (k == 0) ? DIV_A : DIV_B;
      if (!resetnS[k]) begin
        if (mLineLive[k]) abortLine[k] = 1'b1;
        mPendValid[k] = 1'b0;
        mOverrun[k]   = 1'b0;
        mLines[k]     = 16'h0000;
        mLineLive[k]  = 1'b0;
        mLineEnd[k]   = cyc;
      end else begin
        if (mLineLive[k] && cyc == mLineEnd[k]) begin
          mLines[k]++;
          mLineLive[k] = 1'b0;
        end
        consume = mPendValid[k] && !mLineLive[k] && (cyc > mLineEnd[k]);
        if (consume) begin
          expQ.push_back('{k, cyc, mPendAddr[k], mPendValue[k]});
          mLineEnd[k]  = cyc + 130 * div;
          mLineLive[k] = 1'b1;
        end
        ovrEvent = strobeS[k] && mPendValid[k] && !consume;
        if (strobeS[k]) begin
          mPendValid[k] = 1'b1;
          mPendAddr[k]  = addrS[k];
          mPendValue[k] = valueS[k];
        end else if (consume) begin
          mPendValid[k] = 1'b0;
        end
        if (ovrEvent) mOverrun[k] = 1'b1;
        else if (clrS[k]) mOverrun[k] = 1'b0;
      end
    end
  endtask

  // Monitor: status outputs every cycle, and the wire level of every cycle of every frame.
  task automatic monitorStep();
    int div, off, chIdx, bitIdx;
    logic [7:0] expChar;
    logic expLvl;
    for (int k = 0; k < 2; k++) begin
      div = (k == 0) ? DIV_A : DIV_B;
      checkOutput($sformatf("dut%0d busy", k), 32'(busyO[k]), 32'(mPendValid[k] || mLineLive[k]));
      checkOutput($sformatf("dut%0d overrun", k), 32'(overrunO[k]), 32'(mOverrun[k]));
      checkOutput($sformatf("dut%0d lines_sent", k), 32'(linesO[k]), 32'(mLines[k]));
      if (abortLine[k]) begin
        monActive[k] = 1'b0;
        abortLine[k] = 1'b0;
      end
      if (!monActive[k] && serTx[k] == 1'b0) begin
        checkOutput($sformatf("dut%0d lineQueued", k),
                    32'(expQ.size() != 0 && expQ[0].dut == k), 32'd1);
        if (expQ.size() != 0 && expQ[0].dut == k) begin
          monLine[k] = expQ.pop_front();
          checkOutput($sformatf("dut%0d lineStartCycle", k), 32'(cyc), 32'(monLine[k].startCyc));
        end else begin
          monLine[k] = '{k, cyc, 8'h00, 32'h0};
        end
        monActive[k] = 1'b1;
        monStart[k]  = cyc;
        badCycles[k] = 0;
        gotChar[k]   = 8'h00;
      end
      if (monActive[k]) begin
        off     = cyc - monStart[k];
        chIdx   = off / (10 * div);
        bitIdx  = (off / div) % 10;
        expChar = lineChar(monLine[k], chIdx);
        expLvl  = (bitIdx == 0) ? 1'b0 : (bitIdx == 9) ? 1'b1 : expChar[bitIdx - 1];
        if (serTx[k] !== expLvl) badCycles[k]++;
        if (bitIdx >= 1 && bitIdx <= 8 && (off % div) == div / 2) gotChar[k][bitIdx - 1] = serTx[k];
        if ((off % (10 * div)) == 10 * div - 1) begin
          checkOutput($sformatf("dut%0d char%0d", k, chIdx), 32'(gotChar[k]), 32'(expChar));
          checkOutput($sformatf("dut%0d char%0d badBitCycles", k, chIdx), 32'(badCycles[k]), 32'd0);
          badCycles[k] = 0;
        end
        if (off == 130 * div - 1) monActive[k] = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
      #1;
      monitorStep();
    end
  end

  task automatic applyStimulus(input int k, input bit stb, input logic [7:0] a,
                               input logic [31:0] v, input bit clr);
    @(negedge clk);
    strobeS[k] = stb;
    addrS[k]   = a;
    valueS[k]  = v;
    clrS[k]    = clr;
  endtask

  task automatic idleInputs(input int k);
    @(negedge clk);
    strobeS[k] = 1'b0;
    clrS[k]    = 1'b0;
  endtask

  task automatic drainWait(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      done = (expQ.size() == 0) && !monActive[0] && !monActive[1] && (busyO == 2'b00);
    end
    checkOutput({name, " drained"}, 32'(done), 32'd1);
  endtask

  initial begin
    resetnS      = 2'b00;
    strobeS      = 2'b00;
    clrS         = 2'b00;
    addrS        = '0;
    valueS       = '0;
    presetLinesB = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset ser_tx", 32'(serTx), 32'h3);
    checkOutput("reset busy", 32'(busyO), 32'h0);
    checkOutput("reset overrun", 32'(overrunO), 32'h0);
    checkOutput("reset lines_sent A", 32'(linesO[0]), 32'h0);
    resetnS = 2'b11;
    repeat (2) @(negedge clk);

    $display("[TB] basic line");
    applyStimulus(0, 1'b1, 8'h01, 32'h0000_0300, 1'b0);
    idleInputs(0);
    checkOutput("busy after strobe", 32'(busyO[0]), 32'd1);
    @(negedge clk);
    checkOutput("start bit driven", 32'(serTx[0]), 32'd0);
    drainWait("basic");
    checkOutput("lines after basic", 32'(linesO[0]), 32'd1);

    $display("[TB] hex alphabet");
    applyStimulus(0, 1'b1, 8'hAF, 32'hDEAD_BEEF, 1'b0);
    idleInputs(0);
    drainWait("hexA");
    applyStimulus(0, 1'b1, 8'h9A, 32'h090A_090A, 1'b0);
    idleInputs(0);
    drainWait("hexB");
    checkOutput("lines after hex", 32'(linesO[0]), 32'd3);

    $display("[TB] pending and overrun");
    applyStimulus(0, 1'b1, 8'h11, 32'h1111_AAAA, 1'b0);
    idleInputs(0);
    repeat (120) @(negedge clk);
    applyStimulus(0, 1'b1, 8'h22, 32'h2222_BBBB, 1'b0);
    idleInputs(0);
    repeat (78) @(negedge clk);
    applyStimulus(0, 1'b1, 8'h33, 32'h3333_CCCC, 1'b0);
    idleInputs(0);
    checkOutput("overrun after overwrite", 32'(overrunO[0]), 32'd1);
    applyStimulus(0, 1'b0, 8'h00, 32'h0, 1'b1);
    idleInputs(0);
    checkOutput("overrun after clear", 32'(overrunO[0]), 32'd0);
    drainWait("overrun");
    checkOutput("lines after overrun", 32'(linesO[0]), 32'd5);

    $display("[TB] coincident consume and strobe");
    applyStimulus(0, 1'b1, 8'h44, 32'h4444_0001, 1'b0);
    applyStimulus(0, 1'b1, 8'h55, 32'h5555_0002, 1'b0);
    idleInputs(0);
    checkOutput("overrun on coincident", 32'(overrunO[0]), 32'd0);
    repeat (20) @(negedge clk);
    applyStimulus(0, 1'b1, 8'h66, 32'h6666_0003, 1'b1);
    idleInputs(0);
    checkOutput("overrun set beats clear", 32'(overrunO[0]), 32'd1);
    applyStimulus(0, 1'b0, 8'h00, 32'h0, 1'b1);
    idleInputs(0);
    drainWait("coincident");
    checkOutput("lines after coincident", 32'(linesO[0]), 32'd7);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 1'b1, 8'h77, 32'h7777_7777, 1'b0);
    idleInputs(0);
    repeat (100) @(negedge clk);
    applyStimulus(0, 1'b1, 8'h88, 32'h8888_8888, 1'b0);
    idleInputs(0);
    repeat (150) @(negedge clk);
    resetnS[0] = 1'b0;
    @(negedge clk);
    checkOutput("midreset ser_tx", 32'(serTx[0]), 32'd1);
    checkOutput("midreset busy", 32'(busyO[0]), 32'd0);
    checkOutput("midreset lines_sent", 32'(linesO[0]), 32'd0);
    resetnS[0] = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("pending dropped by reset", 32'(busyO[0]), 32'd0);
    applyStimulus(0, 1'b1, 8'h5C, 32'hC0FF_EE12, 1'b0);
    idleInputs(0);
    drainWait("after reset");
    checkOutput("lines after reset", 32'(linesO[0]), 32'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 600)) @(negedge clk);
      applyStimulus(0, 1'b1, 8'($urandom), 32'($urandom), ($urandom_range(0, 3) == 0));
      idleInputs(0);
    end
    drainWait("random");

    $display("[TB] minimum divider and wrap");
    @(negedge clk);
    force dutB.lines_sent_q = 16'hFFFF;
    presetLinesB = 1'b1;
    @(negedge clk);
    release dutB.lines_sent_q;
    presetLinesB = 1'b0;
    @(negedge clk);
    checkOutput("lines preset B", 32'(linesO[1]), 32'hFFFF);
    applyStimulus(1, 1'b1, 8'($urandom), 32'($urandom), 1'b0);
    idleInputs(1);
    drainWait("wrap");
    checkOutput("lines wrapped B", 32'(linesO[1]), 32'h0000);

    checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
